// File: rtl/noc_pkg.sv
// Shared NoC router definitions: output direction one-hots, source indices, arbiter FSM states.
// Pure declarations, no timing.
// No flow control of its own.
package noc_pkg;

    localparam int IDX_W = 3;

    // Output direction one-hot codes (selects which port an arbiter instance drives)
    localparam logic [4:0] DIR_L  = 5'b10000;
    localparam logic [4:0] DIR_R  = 5'b01000;
    localparam logic [4:0] DIR_U  = 5'b00100;
    localparam logic [4:0] DIR_D  = 5'b00010;
    localparam logic [4:0] DIR_PE = 5'b00001;

    // Source indices into req_in / buf_clear
    localparam logic [IDX_W-1:0] IDX_L  = 3'd0;
    localparam logic [IDX_W-1:0] IDX_R  = 3'd1;
    localparam logic [IDX_W-1:0] IDX_U  = 3'd2;
    localparam logic [IDX_W-1:0] IDX_D  = 3'd3;
    localparam logic [IDX_W-1:0] IDX_PE = 3'd4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Round-robin pointer advance: one past the winner, PE wraps back to L
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_PE) ? IDX_L : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among NUM_IN requests, search starting at ptr and wrapping.
// Purely combinational, zero latency.
// No backpressure; caller decides whether the grant is used.
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN = 5
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_IN-1:0] gnt_oh,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    logic [IDX_W-1:0] pos;

    // Walk from the farthest offset back to ptr so the closest requester wins last
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        pos     = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            pos = IDX_W'((int'(ptr) + k) % NUM_IN);
            if (req[pos]) begin
                gnt_vld     = 1'b1;
                gnt_oh      = '0;
                gnt_oh[pos] = 1'b1;
                gnt_idx     = pos;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// One-flit output buffer fed by a round-robin choice among the five router inputs.
// Latency: request seen while empty -> so and buf_clear high the following cycle.
// Backpressure: ro=0 while full freezes datao, so and ptr; refills on the same edge it drains.
module output_arbiter
    import noc_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter logic [4:0] DIRECTION  = DIR_PE,
    parameter int         NUM_IN     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN-1:0]     req_in,
    input  logic [DATA_WIDTH-1:0] data_inL,
    input  logic [DATA_WIDTH-1:0] data_inR,
    input  logic [DATA_WIDTH-1:0] data_inU,
    input  logic [DATA_WIDTH-1:0] data_inD,
    input  logic [DATA_WIDTH-1:0] data_inPE,
    input  logic                  ro,
    output logic                  so,
    output logic [DATA_WIDTH-1:0] datao,
    output logic [NUM_IN-1:0]     buf_clear,
    output logic [IDX_W-1:0]      grant_idx
);

    generate
        if (!(DIRECTION == DIR_L || DIRECTION == DIR_R || DIRECTION == DIR_U ||
              DIRECTION == DIR_D || DIRECTION == DIR_PE) || NUM_IN != 5) begin : g_bad_cfg
            $error("output_arbiter: DIRECTION must be a single port one-hot and NUM_IN must be 5");
        end
    endgenerate

    state_t                state, state_nxt;
    logic [NUM_IN-1:0]     elig;
    logic [NUM_IN-1:0]     gnt_oh;
    logic [IDX_W-1:0]      gnt_idx;
    logic [IDX_W-1:0]      ptr;
    logic                  gnt_vld;
    logic                  accept;
    logic                  do_grant;
    logic [DATA_WIDTH-1:0] sel_dat;

    // A source still being cleared may show its old request for one more cycle
    assign elig     = req_in & ~buf_clear;
    assign accept   = (state == ST_EMPTY) || ro;
    assign do_grant = accept && gnt_vld;
    assign so       = (state == ST_FULL);

    rr_arbiter #(.NUM_IN(NUM_IN)) u_rr_arbiter (
        .req     (elig),
        .ptr     (ptr),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        state_nxt = state;
        if (do_grant) begin
            state_nxt = ST_FULL;
        end else if (state == ST_FULL && ro) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_comb begin
        sel_dat = '0;
        case (gnt_idx)
            IDX_L:   sel_dat = data_inL;
            IDX_R:   sel_dat = data_inR;
            IDX_U:   sel_dat = data_inU;
            IDX_D:   sel_dat = data_inD;
            IDX_PE:  sel_dat = data_inPE;
            default: sel_dat = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            datao     <= '0;
            buf_clear <= '0;
            ptr       <= IDX_L;
            grant_idx <= IDX_L;
        end else begin
            buf_clear <= '0;
            if (do_grant) begin
                datao     <= sel_dat;
                buf_clear <= gnt_oh;
                ptr       <= next_ptr(gnt_idx);
                grant_idx <= gnt_idx;
            end
        end
    end

endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 64, flit width.
REQ-002 Parameter: DIRECTION, 5'b00001, output port this instance drives (L:10000, R:01000, U:00100, D:00010, PE:00001).
REQ-003 Parameter: NUM_IN, 5, number of requesting input interfaces; index 0..4 = L,R,U,D,PE.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_in  input  NUM_IN  per-source request for this output, from each input interface's routing stage.
REQ-007 data_inL, data_inR, data_inU, data_inD, data_inPE  input  DATA_WIDTH each  flit from each source, valid while the matching req_in bit is high.
REQ-008 ro  input  1  downstream ready; transfer occurs on an edge where so=1 and ro=1.
REQ-009 so  output  1  output buffer holds a valid flit.
REQ-010 datao  output  DATA_WIDTH  output buffer contents.
REQ-011 buf_clear  output  NUM_IN  one-hot, one-cycle pulse telling the granted source to drop its flit.
REQ-012 grant_idx  output  3  index of the last granted source (debug).

Function
REQ-013 Two-state FSM: EMPTY (so=0), FULL (so=1); so is a register, never combinational.
REQ-014 Accept condition: state EMPTY, or state FULL with ro=1 in the same cycle.
REQ-015 On an accept cycle with at least one eligible request, the round-robin arbiter SHALL grant exactly one source; datao captures that source's data at the edge, state becomes FULL.
REQ-016 Eligible = req_in[i]=1 and buf_clear[i]=0 in the current cycle (masks stale requests from a source being cleared).
REQ-017 Round-robin: 3-bit pointer ptr, search order ptr, ptr+1, ... wrapping 4->0; after a grant to i, ptr = i+1 (4 wraps to 0).
REQ-018 buf_clear[i] SHALL be high for exactly the one cycle following the edge that captured source i's data; all other bits 0.
REQ-019 FULL with ro=1 and no eligible request: state becomes EMPTY at the edge; datao holds its last value.
REQ-020 FULL with ro=0: datao, so, ptr SHALL hold; no grant, buf_clear=0.
REQ-021 Back-to-back: FULL, ro=1, eligible request -> send and refill on the same edge; sustained throughput one flit per cycle.
REQ-022 Latency: request seen in EMPTY -> so=1 on the next cycle; buf_clear pulses in that same cycle.
REQ-023 datao SHALL be stable while so=1 and ro=0.
REQ-024 grant_idx updates only on a grant.

Reset
REQ-025 On rst=0, immediately: state EMPTY, so=0, datao=0, buf_clear=0, ptr=0, grant_idx=0.
REQ-026 Reset mid-transfer SHALL discard the buffered flit; no buf_clear is issued for it.
REQ-027 The first rising edge after rst deasserts SHALL be a normal accept cycle.

Structure
REQ-028 Shared package noc_pkg holds direction one-hot constants, source index constants (IDX_L..IDX_PE), and the FSM state enum.
REQ-029 One sub-module rr_arbiter (NUM_IN requests, ptr in, one-hot grant and index out, purely combinational); buffer, FSM and ptr register live in output_arbiter.

Verification
REQ-030 Reset: rst=0 with req_in=5'b11111 -> so=0, datao=0, buf_clear=0 until release.
REQ-031 Single request: EMPTY, req_in=00001 (L), data_inL=64'hA5 -> next cycle so=1, datao=64'hA5, buf_clear=00001 for one cycle, ptr=1.
REQ-032 Round-robin fairness: all five requests held, ro=1 -> grants L,R,U,D,PE,L in consecutive cycles, one buf_clear pulse per cycle.
REQ-033 Backpressure: FULL with datao=64'h1, ro=0 for 3 cycles while req_in=00100 -> datao stays 64'h1, buf_clear=0; ro=1 -> next cycle datao=U data, buf_clear=00100.
REQ-034 Stale mask: source R granted, R keeps req_in high during its buf_clear cycle with ro=1 -> R not re-granted that cycle; so drops to 0 if no other request.
REQ-035 Reset mid-operation: FULL, rst=0 pulse -> so=0 immediately; after release, ptr=0 grant order restarts at L.
